// File: rtl/relational_row_fetcher_if.sv
// AXI4 read-address and read-data channel bundle used by the row fetcher
// (master side) and its memory slave.
interface relational_row_fetcher_if #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ID_WIDTH   = 1
);
   logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID;
   logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
   logic [7:0]                    M_AXI_ARLEN;
   logic [2:0]                    M_AXI_ARSIZE;
   logic [1:0]                    M_AXI_ARBURST;
   logic [3:0]                    M_AXI_ARCACHE;
   logic [2:0]                    M_AXI_ARPROT;
   logic                          M_AXI_ARVALID;
   logic                          M_AXI_ARREADY;
   logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA;
   logic [1:0]                    M_AXI_RRESP;
   logic                          M_AXI_RLAST;
   logic                          M_AXI_RVALID;
   logic                          M_AXI_RREADY;

   modport master (
      output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
             M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY,
      input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
   );

   modport slave (
      input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
             M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY,
      output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
   );
endinterface

// File: rtl/relational_row_fetcher.sv
// AXI4 read-burst master: fetches the projected column window of each table row
// (one INCR burst per row) and streams the words to the cache fill port.
module relational_row_fetcher #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ID_WIDTH   = 1,
   parameter int C_MAX_COLS         = 256,
   parameter int C_ROWCNT_WIDTH     = 16
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic                          INIT_AXI_TXN,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] row_stride,
   input  logic [C_ROWCNT_WIDTH-1:0]     row_count,
   input  logic [7:0]                    col_offset,
   input  logic [8:0]                    col_words,
   relational_row_fetcher_if.master      m_axi,
   output logic [C_M_AXI_DATA_WIDTH-1:0] out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_row_last,
   output logic                          out_job_last,
   output logic                          TXN_DONE,
   output logic                          ERROR,
   output logic                          busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_ADDR,
      ST_DATA,
      ST_DONE
   } state_t;

   localparam logic [9:0] MAX_COLS = 10'(C_MAX_COLS);

   state_t                        state_q, state_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0] row_addr_q, row_addr_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0] stride_q, stride_d;
   logic [C_ROWCNT_WIDTH-1:0]     rows_q, rows_d;
   logic [C_ROWCNT_WIDTH-1:0]     row_idx_q, row_idx_d;
   logic [8:0]                    cols_q, cols_d;
   logic [8:0]                    beat_cnt_q, beat_cnt_d;
   logic                          error_q, error_d;

   logic                          arvalid;
   logic                          rready;
   logic                          beat_is_last;
   logic                          row_is_last;
   logic                          cols_bad;
   logic                          crosses_4k;
   logic [13:0]                   span_end;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q    <= ST_IDLE;
         row_addr_q <= '0;
         stride_q   <= '0;
         rows_q     <= '0;
         row_idx_q  <= '0;
         cols_q     <= '0;
         beat_cnt_q <= '0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_addr_q <= row_addr_d;
         stride_q   <= stride_d;
         rows_q     <= rows_d;
         row_idx_q  <= row_idx_d;
         cols_q     <= cols_d;
         beat_cnt_q <= beat_cnt_d;
         error_q    <= error_d;
      end
   end

   // Burst end offset within its 4 KB page; anything past 4096 would cross it.
   assign span_end     = {2'b00, row_addr_q[11:0]} + {3'b000, cols_q, 2'b00};
   assign crosses_4k   = span_end > 14'd4096;
   assign cols_bad     = (cols_q == 9'd0) || ({1'b0, cols_q} > MAX_COLS);
   assign beat_is_last = beat_cnt_q == (cols_q - 9'd1);
   assign row_is_last  = row_idx_q == (rows_q - C_ROWCNT_WIDTH'(1));

   always_comb begin
      state_d      = state_q;
      row_addr_d   = row_addr_q;
      stride_d     = stride_q;
      rows_d       = rows_q;
      row_idx_d    = row_idx_q;
      cols_d       = cols_q;
      beat_cnt_d   = beat_cnt_q;
      error_d      = error_q;
      arvalid      = 1'b0;
      rready       = 1'b0;
      out_data     = '0;
      out_valid    = 1'b0;
      out_row_last = 1'b0;
      out_job_last = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (INIT_AXI_TXN) begin
               stride_d   = row_stride;
               rows_d     = row_count;
               cols_d     = col_words;
               error_d    = 1'b0;
               row_addr_d = base_addr + C_M_AXI_ADDR_WIDTH'({col_offset, 2'b00});
               row_idx_d  = '0;
               beat_cnt_d = '0;
               state_d    = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (row_idx_q == rows_q) begin
               state_d = ST_DONE;
            end else if (cols_bad || crosses_4k) begin
               error_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            arvalid = 1'b1;
            if (m_axi.M_AXI_ARREADY) begin
               beat_cnt_d = '0;
               state_d    = ST_DATA;
            end
         end
         ST_DATA: begin
            out_data     = m_axi.M_AXI_RDATA;
            out_valid    = m_axi.M_AXI_RVALID;
            rready       = out_ready;
            out_row_last = m_axi.M_AXI_RVALID & beat_is_last;
            out_job_last = out_row_last & row_is_last;
            if (m_axi.M_AXI_RVALID && out_ready) begin
               beat_cnt_d = beat_cnt_q + 9'd1;
               if (m_axi.M_AXI_RRESP != 2'b00 || m_axi.M_AXI_RLAST != beat_is_last) begin
                  error_d = 1'b1;
               end
               // The slave's RLAST, not the local beat count, ends the row.
               if (m_axi.M_AXI_RLAST) begin
                  row_addr_d = row_addr_q + stride_q;
                  row_idx_d  = row_idx_q + C_ROWCNT_WIDTH'(1);
                  state_d    = ST_CHECK;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign m_axi.M_AXI_ARID    = C_M_AXI_ID_WIDTH'(0);
   assign m_axi.M_AXI_ARADDR  = row_addr_q;
   assign m_axi.M_AXI_ARLEN   = 8'(cols_q - 9'd1);
   assign m_axi.M_AXI_ARSIZE  = 3'b010;
   assign m_axi.M_AXI_ARBURST = 2'b01;
   assign m_axi.M_AXI_ARCACHE = 4'b0011;
   assign m_axi.M_AXI_ARPROT  = 3'b000;
   assign m_axi.M_AXI_ARVALID = arvalid;
   assign m_axi.M_AXI_RREADY  = rready;

   assign TXN_DONE = state_q == ST_DONE;
   assign ERROR    = error_q;
   assign busy     = (state_q == ST_CHECK) || (state_q == ST_ADDR) || (state_q == ST_DATA);

endmodule

// File: tb/tb_relational_row_fetcher.sv
// Directed bench for relational_row_fetcher: a one-burst AXI read slave with a
// synthetic memory, plus a beat logger checked against hand-derived jobs.
module tb_relational_row_fetcher;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic        INIT_AXI_TXN = 1'b0;
   logic [31:0] base_addr = '0;
   logic [31:0] row_stride = '0;
   logic [15:0] row_count = '0;
   logic [7:0]  col_offset = '0;
   logic [8:0]  col_words = '0;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_row_last;
   logic        out_job_last;
   logic        TXN_DONE;
   logic        ERROR;
   logic        busy;

   int total = 0;
   int bad = 0;

   relational_row_fetcher_if #(
      .C_M_AXI_ADDR_WIDTH(32),
      .C_M_AXI_DATA_WIDTH(32),
      .C_M_AXI_ID_WIDTH(1)
   ) axi_if ();

   relational_row_fetcher #(
      .C_M_AXI_ADDR_WIDTH(32),
      .C_M_AXI_DATA_WIDTH(32),
      .C_M_AXI_ID_WIDTH(1),
      .C_MAX_COLS(256),
      .C_ROWCNT_WIDTH(16)
   ) dut (
      .ACLK(ACLK),
      .ARESETN(ARESETN),
      .INIT_AXI_TXN(INIT_AXI_TXN),
      .base_addr(base_addr),
      .row_stride(row_stride),
      .row_count(row_count),
      .col_offset(col_offset),
      .col_words(col_words),
      .m_axi(axi_if),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_row_last(out_row_last),
      .out_job_last(out_job_last),
      .TXN_DONE(TXN_DONE),
      .ERROR(ERROR),
      .busy(busy)
   );

   always #5 ACLK = ~ACLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] widx);
      return 32'hD500_0000 | (widx & 32'h00FF_FFFF);
   endfunction

   // slave / monitor state
   int          cyc = 0;
   int          ready_mode = 0;
   int          err_ar = -1;
   int          err_beat = -1;
   logic        s_active = 1'b0;
   logic [31:0] s_addr = '0;
   logic [7:0]  s_len = '0;
   logic [7:0]  s_beat = '0;
   logic        ar_hs = 1'b0;
   logic        r_hs = 1'b0;
   logic [31:0] hs_addr = '0;
   logic [7:0]  hs_len = '0;
   int          ar_count = 0;
   logic [31:0] ar_addr_log [0:7];
   logic [7:0]  ar_len_log [0:7];
   int          n_beats = 0;
   logic [31:0] log_data [0:63];
   logic        log_rl [0:63];
   logic        log_jl [0:63];

   initial begin
      axi_if.M_AXI_ARREADY = 1'b0;
      axi_if.M_AXI_RVALID  = 1'b0;
      axi_if.M_AXI_RDATA   = '0;
      axi_if.M_AXI_RRESP   = 2'b00;
      axi_if.M_AXI_RLAST   = 1'b0;
      forever begin
         @(negedge ACLK);
         cyc++;
         if (!ARESETN) begin
            s_active = 1'b0;
            ar_hs    = 1'b0;
            r_hs     = 1'b0;
         end else begin
            if (r_hs) begin
               if (s_beat == s_len) s_active = 1'b0;
               else s_beat = s_beat + 8'd1;
            end
            if (ar_hs) begin
               if (ar_count < 8) begin
                  ar_addr_log[ar_count] = hs_addr;
                  ar_len_log[ar_count]  = hs_len;
               end
               ar_count++;
               s_active = 1'b1;
               s_addr   = hs_addr >> 2;
               s_len    = hs_len;
               s_beat   = '0;
            end
         end
         out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         axi_if.M_AXI_ARREADY = ARESETN && !s_active && (cyc % 2 == 0);
         axi_if.M_AXI_RVALID  = s_active;
         axi_if.M_AXI_RDATA   = mem_word(s_addr + 32'(s_beat));
         axi_if.M_AXI_RLAST   = s_active && (s_beat == s_len);
         axi_if.M_AXI_RRESP   = (s_active && (ar_count - 1 == err_ar) && (int'(s_beat) == err_beat))
                                ? 2'b10 : 2'b00;
         #1;
         ar_hs   = axi_if.M_AXI_ARVALID & axi_if.M_AXI_ARREADY;
         hs_addr = axi_if.M_AXI_ARADDR;
         hs_len  = axi_if.M_AXI_ARLEN;
         r_hs    = axi_if.M_AXI_RVALID & axi_if.M_AXI_RREADY;
         if (axi_if.M_AXI_RVALID) check_eq("rready_mirror", {31'd0, axi_if.M_AXI_RREADY}, {31'd0, out_ready});
         if (out_valid && out_ready && n_beats < 64) begin
            log_data[n_beats] = out_data;
            log_rl[n_beats]   = out_row_last;
            log_jl[n_beats]   = out_job_last;
            n_beats++;
         end
      end
   end

   task automatic start_job(input logic [31:0] b, input logic [31:0] s, input logic [15:0] r,
                            input logic [7:0] o, input logic [8:0] c, input int mode);
      base_addr  = b;
      row_stride = s;
      row_count  = r;
      col_offset = o;
      col_words  = c;
      ready_mode = mode;
      @(negedge ACLK);
      n_beats  = 0;
      ar_count = 0;
      INIT_AXI_TXN = 1'b1;
      @(negedge ACLK);
      INIT_AXI_TXN = 1'b0;
   endtask

   task automatic run_job(input string tag, input logic [31:0] b, input logic [31:0] s,
                          input logic [15:0] r, input logic [7:0] o, input logic [8:0] c,
                          input int mode, input int exp_ars, input logic exp_err);
      int rows_seen;
      logic [31:0] exp_addr;
      start_job(b, s, r, o, c, mode);
      check_eq({tag, "_done_drop"}, {31'd0, TXN_DONE}, 32'd0);
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
      @(negedge ACLK);
      if (exp_ars > 0) check_eq({tag, "_ar_latency"}, {31'd0, axi_if.M_AXI_ARVALID}, 32'd1);
      else             check_eq({tag, "_done_latency"}, {31'd0, TXN_DONE}, 32'd1);
      for (int i = 0; i < 2000 && !TXN_DONE; i++) @(negedge ACLK);
      check_eq({tag, "_done"}, {31'd0, TXN_DONE}, 32'd1);
      check_eq({tag, "_error"}, {31'd0, ERROR}, {31'd0, exp_err});
      check_eq({tag, "_ar_count"}, 32'(ar_count), 32'(exp_ars));
      check_eq({tag, "_beats"}, 32'(n_beats), 32'(exp_ars) * 32'(c));
      rows_seen = (ar_count < exp_ars) ? ar_count : exp_ars;
      for (int k = 0; k < rows_seen && k < 8; k++) begin
         check_eq({tag, "_araddr"}, ar_addr_log[k], b + 32'(k) * s + 32'(o) * 32'd4);
         check_eq({tag, "_arlen"}, {24'd0, ar_len_log[k]}, 32'(c) - 32'd1);
      end
      for (int k = 0; k < n_beats && k < exp_ars * int'(c); k++) begin
         exp_addr = (b + 32'(k / int'(c)) * s + 32'(o) * 32'd4) / 32'd4 + 32'(k % int'(c));
         check_eq({tag, "_data"}, log_data[k], mem_word(exp_addr));
         check_eq({tag, "_row_last"}, {31'd0, log_rl[k]}, {31'd0, (k % int'(c)) == int'(c) - 1});
         check_eq({tag, "_job_last"}, {31'd0, log_jl[k]}, {31'd0, k == exp_ars * int'(c) - 1});
      end
   endtask

   initial begin
      repeat (3) @(negedge ACLK);
      check_eq("rst_arvalid", {31'd0, axi_if.M_AXI_ARVALID}, 32'd0);
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_done", {31'd0, TXN_DONE}, 32'd0);
      check_eq("rst_error", {31'd0, ERROR}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      ARESETN = 1'b1;
      repeat (2) @(negedge ACLK);

      run_job("basic", 32'h1000, 32'd64, 16'd3, 8'd2, 9'd4, 0, 3, 1'b0);
      run_job("toggle", 32'h1000, 32'd64, 16'd3, 8'd2, 9'd4, 1, 3, 1'b0);
      err_ar = 1; err_beat = 1;
      run_job("slverr", 32'h1000, 32'd64, 16'd3, 8'd2, 9'd4, 0, 3, 1'b1);
      err_ar = -1; err_beat = -1;
      run_job("cross4k", 32'h0FF8, 32'd64, 16'd2, 8'd0, 9'd4, 0, 0, 1'b1);
      run_job("zero_rows", 32'h1000, 32'd64, 16'd0, 8'd2, 9'd4, 0, 0, 1'b0);
      run_job("restart", 32'h2000, 32'd32, 16'd2, 8'd1, 9'd3, 0, 2, 1'b0);
      run_job("bad_cols", 32'h1000, 32'd64, 16'd1, 8'd0, 9'd0, 0, 0, 1'b1);

      start_job(32'h1000, 32'd64, 16'd3, 8'd2, 9'd4, 0);
      for (int i = 0; i < 200 && n_beats < 5; i++) @(negedge ACLK);
      check_eq("mid_beats_reached", {31'd0, n_beats >= 5}, 32'd1);
      #2;
      ARESETN = 1'b0;
      #1;
      check_eq("arst_arvalid", {31'd0, axi_if.M_AXI_ARVALID}, 32'd0);
      check_eq("arst_rready", {31'd0, axi_if.M_AXI_RREADY}, 32'd0);
      check_eq("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("arst_busy", {31'd0, busy}, 32'd0);
      check_eq("arst_done", {31'd0, TXN_DONE}, 32'd0);
      repeat (3) @(negedge ACLK);
      ARESETN = 1'b1;
      @(negedge ACLK);
      run_job("after_rst", 32'h1000, 32'd64, 16'd3, 8'd2, 9'd4, 0, 3, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
